qick_port_dispatch: RTL and testbench

Timed output queue directly downstream of the QICK processor port-write stage. Accepts `PORT_DT` words (32-bit `p_time`, 1-bit `p_type`, 4-bit `p_addr`, 168-bit `p_data`) on `port_we_i`, buffers them in order, and releases each one at its scheduled time. A released word goes out as a one-cycle strobe on the addressed wave or data port, together with its payload.

---
 rtl/qick_port_dispatch.sv | 137 +++++++++++++
 tb/tb_qick_port_dispatch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/qick_port_dispatch.sv
// Timed output queue behind the QICK port-write stage: buffers PORT_DT words in order
// and releases each as a one-cycle wave/data strobe once time_i reaches its p_time.
module qick_port_dispatch #(
  parameter int FIFO_AW = 4,
  parameter int NP      = 16
) (
  input  logic                t_clk_i,
  input  logic                t_rst_i,
  input  logic [31:0]         time_i,
  input  logic                time_en_i,
  input  logic                port_we_i,
  input  logic [204:0]        port_dt_i,
  input  logic                flush_i,
  input  logic                err_clr_i,
  output logic [NP-1:0]       wave_vld_o,
  output logic [NP-1:0]       data_vld_o,
  output logic [167:0]        port_dt_o,
  output logic [FIFO_AW:0]    fifo_cnt_o,
  output logic                fifo_full_o,
  output logic                fifo_empty_o,
  output logic                err_ovf_o,
  output logic                err_late_o,
  output logic                err_addr_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = 1;
  localparam logic [4:0] NP_W = 5'(NP);

  logic [204:0]     mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, rd_ptr_inc;
  logic [204:0]     head_dt;
  logic             head_vld;

  logic [31:0]  head_time, diff;
  logic         head_type;
  logic [3:0]   head_addr;
  logic [167:0] head_data;
  logic         full, empty, due, pop, push, addr_ok;
  logic         ovf_evt, late_evt, addr_evt;
  logic [NP-1:0] one_hot;

  assign head_time = head_dt[204:173];
  assign head_type = head_dt[172];
  assign head_addr = head_dt[171:168];
  assign head_data = head_dt[167:0];

  // Wrap-safe compare: anything up to 2^31-1 ahead is still in the future.
  assign diff = time_i - head_time;
  assign due  = ~diff[31];

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = ((wr_ptr ^ rd_ptr) == {1'b1, {FIFO_AW{1'b0}}});
  assign rd_ptr_inc = rd_ptr + PTR_ONE;

  assign pop      = head_vld & time_en_i & due & ~flush_i;
  assign push     = port_we_i & (~full | pop) & ~flush_i;
  assign ovf_evt  = port_we_i & full & ~pop & ~flush_i;
  assign addr_ok  = ({1'b0, head_addr} < NP_W);
  assign late_evt = pop & (diff != 32'd0);
  assign addr_evt = pop & ~addr_ok;
  assign one_hot  = NP'(1) << head_addr;

  always_comb begin
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    if (flush_i) begin
      wr_ptr_nx = '0;
      rd_ptr_nx = '0;
    end else begin
      if (push) wr_ptr_nx = wr_ptr + PTR_ONE;
      if (pop)  rd_ptr_nx = rd_ptr_inc;
    end
  end

  always_ff @(posedge t_clk_i) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= port_dt_i;
  end

  always_ff @(posedge t_clk_i or posedge t_rst_i) begin
    if (t_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
    end
  end

  // Head mirrors mem[rd_ptr]; on a pop it refills from the next slot in the same edge.
  always_ff @(posedge t_clk_i or posedge t_rst_i) begin
    if (t_rst_i) begin
      head_vld <= 1'b0;
      head_dt  <= '0;
    end else if (flush_i) begin
      head_vld <= 1'b0;
    end else if (pop) begin
      head_vld <= (rd_ptr_inc != wr_ptr);
      head_dt  <= mem[rd_ptr_inc[FIFO_AW-1:0]];
    end else if (!head_vld && !empty) begin
      head_vld <= 1'b1;
      head_dt  <= mem[rd_ptr[FIFO_AW-1:0]];
    end
  end

  always_ff @(posedge t_clk_i or posedge t_rst_i) begin
    if (t_rst_i) begin
      wave_vld_o   <= '0;
      data_vld_o   <= '0;
      port_dt_o    <= '0;
      fifo_cnt_o   <= '0;
      fifo_full_o  <= 1'b0;
      fifo_empty_o <= 1'b1;
    end else begin
      wave_vld_o   <= (pop && addr_ok && !head_type) ? one_hot : '0;
      data_vld_o   <= (pop && addr_ok &&  head_type) ? one_hot : '0;
      if (pop && addr_ok) port_dt_o <= head_data;
      fifo_cnt_o   <= wr_ptr_nx - rd_ptr_nx;
      fifo_full_o  <= ((wr_ptr_nx ^ rd_ptr_nx) == {1'b1, {FIFO_AW{1'b0}}});
      fifo_empty_o <= (wr_ptr_nx == rd_ptr_nx);
    end
  end

  // A new error event in the same cycle as err_clr_i keeps the flag set.
  always_ff @(posedge t_clk_i or posedge t_rst_i) begin
    if (t_rst_i) begin
      err_ovf_o  <= 1'b0;
      err_late_o <= 1'b0;
      err_addr_o <= 1'b0;
    end else begin
      err_ovf_o  <= ovf_evt  | (err_ovf_o  & ~err_clr_i);
      err_late_o <= late_evt | (err_late_o & ~err_clr_i);
      err_addr_o <= addr_evt | (err_addr_o & ~err_clr_i);
    end
  end

endmodule

// File: tb/tb_qick_port_dispatch.sv
// Directed bench for qick_port_dispatch with a 4-deep queue and 8 output ports.
module tb_qick_port_dispatch;
  localparam int AW = 2;
  localparam int NP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   time_v = '0;
  logic          time_en = 1'b0;
  logic          we = 1'b0;
  logic [204:0]  dt_in = '0;
  logic          flush = 1'b0;
  logic          err_clr = 1'b0;
  logic [NP-1:0] wave_vld, data_vld;
  logic [167:0]  port_dt;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty, err_ovf, err_late, err_addr;

  int n_cmp = 0;
  int n_bad = 0;
  bit count_up = 1'b0;

  qick_port_dispatch #(.FIFO_AW(AW), .NP(NP)) dut (
    .t_clk_i(clk), .t_rst_i(rst), .time_i(time_v), .time_en_i(time_en),
    .port_we_i(we), .port_dt_i(dt_in), .flush_i(flush), .err_clr_i(err_clr),
    .wave_vld_o(wave_vld), .data_vld_o(data_vld), .port_dt_o(port_dt),
    .fifo_cnt_o(fifo_cnt), .fifo_full_o(fifo_full), .fifo_empty_o(fifo_empty),
    .err_ovf_o(err_ovf), .err_late_o(err_late), .err_addr_o(err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [167:0] got, input logic [167:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (count_up) time_v = time_v + 32'd1;
  endtask

  function automatic logic [204:0] mk(input logic [31:0] t, input logic ty,
                                      input logic [3:0] a, input logic [167:0] d);
    return {t, ty, a, d};
  endfunction

  task automatic push(input logic [204:0] w);
    we = 1'b1;
    dt_in = w;
    step();
    we = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  initial begin
    step();
    check("rst_empty", 168'(fifo_empty), 168'(1));
    check("rst_cnt",   168'(fifo_cnt),   168'(0));
    check("rst_full",  168'(fifo_full),  168'(0));
    check("rst_wave",  168'(wave_vld),   168'(0));
    check("rst_data",  168'(data_vld),   168'(0));
    check("rst_dt",    port_dt,          168'(0));
    check("rst_errs",  168'({err_ovf, err_late, err_addr}), 168'(0));
    rst = 1'b0;
    step();

    // On-time single release: strobe lands in the cycle time_i == 101.
    time_en = 1'b1;
    time_v = 32'd50;
    push(mk(32'd100, 1'b0, 4'd3, 168'hA5));
    step();
    step();
    check("t1_early", 168'(wave_vld), 168'(0));
    time_v = 32'd97;
    count_up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t1_wave", 168'(wave_vld), (time_v == 32'd101) ? 168'h08 : 168'h0);
      check("t1_data", 168'(data_vld), 168'(0));
    end
    count_up = 1'b0;
    check("t1_dt",   port_dt, 168'hA5);
    check("t1_late", 168'(err_late), 168'(0));

    // Three overdue data entries dispatch on consecutive cycles.
    time_v = 32'd20;
    for (int i = 0; i < 3; i++) push(mk(32'd10, 1'b1, 4'(i), 168'h100 + 168'(i)));
    check("t2_s0", 168'(data_vld), 168'h1);
    step();
    check("t2_s1", 168'(data_vld), 168'h2);
    step();
    check("t2_s2", 168'(data_vld), 168'h4);
    check("t2_dt", port_dt, 168'h102);
    check("t2_wave", 168'(wave_vld), 168'(0));
    step();
    check("t2_s3", 168'(data_vld), 168'h0);
    check("t2_late", 168'(err_late), 168'(1));

    // Overflow of the 4-deep queue, then drain in order.
    pulse_clr();
    time_en = 1'b0;
    time_v = 32'd30;
    for (int i = 0; i < 5; i++) push(mk(32'd0, 1'b0, 4'(i), 168'h200 + 168'(i)));
    step();
    check("t3_full",  168'(fifo_full),  168'(1));
    check("t3_cnt",   168'(fifo_cnt),   168'(4));
    check("t3_ovf",   168'(err_ovf),    168'(1));
    check("t3_empty", 168'(fifo_empty), 168'(0));
    time_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t3_wave", 168'(wave_vld), (i < 4) ? (168'h1 << i) : 168'h0);
      if (i < 4) check("t3_dt", port_dt, 168'h200 + 168'(i));
    end
    check("t3_cnt_end",   168'(fifo_cnt),   168'(0));
    check("t3_empty_end", 168'(fifo_empty), 168'(1));

    // Time counter wrap-around: p_time 5 is in the future at 0xFFFF_FFF0.
    pulse_clr();
    time_v = 32'hFFFF_FFF0;
    push(mk(32'd5, 1'b0, 4'd5, 168'h3C3));
    count_up = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      check("t4_wave", 168'(wave_vld), (time_v == 32'd6) ? 168'h20 : 168'h0);
    end
    count_up = 1'b0;
    check("t4_late", 168'(err_late), 168'(0));
    check("t4_dt",   port_dt, 168'h3C3);

    // Out-of-range address: popped silently, flag set, payload untouched.
    time_v = 32'd100;
    push(mk(32'd100, 1'b0, 4'd15, 168'h777));
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_wave", 168'(wave_vld), 168'(0));
      check("t5_data", 168'(data_vld), 168'(0));
    end
    check("t5_addr",  168'(err_addr),   168'(1));
    check("t5_dt",    port_dt,          168'h3C3);
    check("t5_empty", 168'(fifo_empty), 168'(1));
    pulse_clr();
    check("t5_clr",   168'(err_addr),   168'(0));

    // Flush together with a push.
    time_en = 1'b0;
    for (int i = 0; i < 3; i++) push(mk(32'd0, 1'b0, 4'(i), 168'h400 + 168'(i)));
    we = 1'b1;
    flush = 1'b1;
    dt_in = mk(32'd0, 1'b0, 4'd6, 168'h499);
    step();
    we = 1'b0;
    flush = 1'b0;
    check("t6_empty", 168'(fifo_empty), 168'(1));
    check("t6_cnt",   168'(fifo_cnt),   168'(0));
    check("t6_ovf",   168'(err_ovf),    168'(0));
    time_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_wave", 168'(wave_vld), 168'(0));
    end

    // Asynchronous reset with entries queued.
    time_en = 1'b0;
    for (int i = 0; i < 3; i++) push(mk(32'd0, 1'b1, 4'(i), 168'h500 + 168'(i)));
    #2 rst = 1'b1;
    #1;
    check("t7_empty", 168'(fifo_empty), 168'(1));
    check("t7_cnt",   168'(fifo_cnt),   168'(0));
    check("t7_dt",    port_dt,          168'(0));
    step();
    rst = 1'b0;
    time_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t7_data", 168'(data_vld), 168'(0));
      check("t7_wave", 168'(wave_vld), 168'(0));
    end
    check("t7_empty_end", 168'(fifo_empty), 168'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
